// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues icache reads and buffers {word, pc} for decode.
// Latency: ihit at edge N shows as inst_valid in cycle N+1; requests stop when the buffer is full or on stall backpressure.

module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_rdy,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop_rdy)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_vld, pop_rdy})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the pointers and count qualify every read.
    always_ff @(posedge clk) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int          DEPTH   = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_npc,
    output logic        halted
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [31:0] fpc;
    logic        halted_q;
    logic [AW:0] count;
    logic [63:0] head_dat;
    logic        push;
    logic        pop;
    logic        flush;

    assign imemREN    = nRST & ~halted_q & (count < FULL);
    assign imemaddr   = nRST ? fpc : PC_INIT;
    assign inst_valid = nRST & ~halted_q & (count != '0);
    assign halted     = nRST & halted_q;

    // Redirect and halt both kill any same-cycle response and the head pop.
    assign push  = ihit & imemREN & ~redirect & ~halt;
    assign pop   = inst_valid & ~stall & ~redirect & ~halt;
    assign flush = redirect | halt;

    fetch_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk      (CLK),
        .rst_n    (nRST),
        .flush    (flush),
        .push_vld (push),
        .push_dat ({imemload, fpc}),
        .pop_rdy  (pop),
        .head_dat (head_dat),
        .count    (count)
    );

    assign inst     = head_dat[63:32];
    assign inst_pc  = head_dat[31:0];
    assign inst_npc = inst_pc + 32'd4;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            fpc      <= PC_INIT;
            halted_q <= 1'b0;
        end else if (halt) begin
            halted_q <= 1'b1;
        end else if (!halted_q) begin
            if (redirect)
                fpc <= redirect_pc & ~32'h3;
            else if (push)
                fpc <= fpc + 32'd4;
        end
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control unit and decode stage.
- Owns the fetch PC and issues instruction reads to the icache/memory port.
- Buffers returned words with their PCs in a small FIFO and presents the head instruction to decode. Decode consumes `inst` and drives the control unit's `inst`/`op`/`rfunc` inputs.
- Accepts branch/jump redirects and halt from downstream.

Parameters:
- PC_INIT, 32'h0000_0000, fetch PC after reset.
- DEPTH, 2, instruction buffer entries; power of two, ≥2.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  synchronous active-low reset.
- ihit  input  1  read response valid for current imemaddr.
- imemload  input  32  instruction word returned with ihit.
- imemREN  output  1  instruction read request.
- imemaddr  output  32  fetch address.
- stall  input  1  decode cannot accept the head this cycle.
- redirect  input  1  branch taken or jump resolved.
- redirect_pc  input  32  new fetch target.
- halt  input  1  halt decoded downstream.
- inst_valid  output  1  head entry valid.
- inst  output  32  head instruction word.
- inst_pc  output  32  PC of head instruction.
- inst_npc  output  32  inst_pc + 4.
- halted  output  1  sticky halted status.

Behaviour:
- **Clocking and reset:**
  - One clock, CLK.
  - Reset is synchronous and active-low on nRST: sampled only on the rising CLK edge.
- **State:**
  - fpc (32b fetch PC).
  - FIFO of DEPTH entries {word, pc}, with rd/wr pointers and a count of width log2(DEPTH)+1.
  - halted flag.
- **Reset (nRST=0 at edge):**
  - fpc=PC_INIT, count=0, pointers=0, halted=0.
  - While nRST is low: imemREN=0, inst_valid=0, imemaddr=PC_INIT, halted=0.
- **Request:**
  - imemREN = nRST & !halted & (count < DEPTH).
  - imemaddr = fpc.
  - imemaddr is held stable while imemREN=1 until ihit, unless redirect.
  - ihit is ignored when imemREN=0.
- **Push:** ihit & imemREN & !redirect & !halt → write {imemload, fpc} at wr pointer, fpc <= fpc+4 (mod 2^32 wrap), wr pointer++.
- **Pop:** inst_valid & !stall & !redirect & !halt → rd pointer++.
- **Simultaneous push and pop:** count unchanged. Legal at any count < DEPTH.
- **Outputs:**
  - inst_valid = (count != 0) & !halted.
  - inst, inst_pc = head entry.
  - inst_npc = inst_pc+4.
  - inst and inst_pc are don't-care when inst_valid=0.
- **Redirect (priority over push/pop):**
  - Flush FIFO (count=0, pointers reset).
  - fpc <= {redirect_pc[31:2], 2'b00}.
  - A same-cycle ihit response is discarded.
  - The next cycle requests the new target.
- **Halt (priority over redirect):**
  - halted <= 1, FIFO flushed, any ihit dropped.
  - Thereafter imemREN=0 and inst_valid=0; fpc frozen.
  - Cleared only by reset.
- **Priority:** reset > halt > redirect > push/pop.
- **Boundary conditions:**
  - Full (count=DEPTH): no request; a pop frees a slot and the request reasserts next cycle.
  - Empty: inst_valid=0, and stall has no effect.
  - Reset mid-request: outstanding read is abandoned; no push occurs.
- **Latency:**
  - ihit at edge N → inst_valid=1 in cycle N+1 when the FIFO was empty.
  - Zero-wait memory sustains one instruction per cycle.

Test Plan:
1. **Sequential fetch:** PC_INIT=0, ihit=1 every cycle, stall=0, 5 cycles → inst_pc sequence 0,4,8,C,10; inst = imemload of the prior cycle; inst_npc = inst_pc+4.
2. **Stall fill:** stall=1 with ihit=1 → after 2 hits count=2, imemREN=0, imemaddr=8. Release stall → head pc 0 then 4, and imemREN reasserts the cycle after the first pop.
3. **Redirect and ihit collide:** fpc=0x20, ihit=1 with imemload=0xDEADBEEF, redirect=1, redirect_pc=0x103 in the same cycle → next cycle inst_valid=0, imemaddr=0x100, 0xDEADBEEF never appears on inst.
4. **Halt:** halt=1 with 2 entries buffered → next cycle halted=1, inst_valid=0, imemREN=0. Stays so for 10 cycles despite ihit and redirect pulses.
5. **Reset mid-operation:** nRST=0 for 1 cycle while imemREN=1 at 0x40 and count=1 → after the edge imemaddr=PC_INIT, count=0, halted=0. An ihit during the reset cycle is not pushed.
6. **Wrap:** redirect_pc=0xFFFFFFFC, ihit → next fetch address 0x00000000; inst_npc of the head = 0x00000000.
